mac_array_pipe: RTL and testbench
=================================

// Module: mac_array_pipe
// PURPOSE
//  LANES-wide pipelined signed fixed-point multiply-accumulate, the parametrised successor to the single-lane MAC.
//  Each accepted beat carries one (a,b) pair per lane. All lanes share one valid/ready handshake and one stream framing.
//  Accumulates a dot-product stream per lane. Emits the sums on the beat flagged last.
//  Sits between the operand feeder and the TPU result collector.
// PARAMETERS
//  N      32  operand, product and accumulator width (signed, two's complement)
//  Q      10  fractional bits (QN-Q.Q format), 0 < Q < N
//  LANES  4   number of independent MAC lanes
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous reset, active-low
//  in_valid   in   1         input beat valid
//  in_ready   out  1         input beat accepted when in_valid & in_ready
//  in_clear   in   1         beat starts a new stream; discards any partial sum
//  in_last    in   1         beat is the final term of the stream
//  a          in   LANES*N   lane i operand = a[i*N +: N]
//  b          in   LANES*N   lane i operand = b[i*N +: N]
//  out_valid  out  1         result valid; held until out_ready
//  out_ready  in   1         result taken when out_valid & out_ready
//  out_acc    out  LANES*N   per-lane accumulated sum, same lane packing as a/b
//  out_ovf    out  LANES     per-lane sticky overflow for the reported stream
// BEHAVIOUR
//  Reset (rst_n low, async): all pipeline regs, accumulators, out_acc, out_ovf and out_valid go to 0.
//  - in_ready is 1 once rst_n deasserts.
//  - Reset mid-stream drops the partial sums and any pending result.
//  stall = out_valid & ~out_ready. in_ready = ~stall (combinational). The whole pipe freezes while stall=1.
//  S1 multiply, at the accepting edge E:
//  - p_full = a_i*b_i, 2N-bit.
//  - p = p_full >>> Q (arithmetic shift, rounds toward -inf).
//  - The product overflows if p does not fit N signed bits.
//  - Registered with the clear, last and valid flags.
//  S2 accumulate, at edge E+1 when S1 is valid and not stalled:
//  - base = 0 if S1.clear or first beat after a last, else acc.
//  - acc_next = base + p, computed at N+1 bits.
//  - The add overflows if the N+1-bit sum is out of N-bit range.
//  - ovf_sticky = (clear ? 0 : ovf_sticky) | product_ovf | add_ovf.
//  - If S1.last: out_acc <= acc_next, out_ovf <= sticky, out_valid <= 1, and the accumulator returns to the idle/zero base.
//  Latency: beat accepted at edge E; its result appears with out_valid high from edge E+1.
//  Throughput: one beat per clock while out_ready is held high.
//  out_valid drops on the edge where out_ready=1 with no new last result arriving.
//  - If a new last result arrives on that same edge, out_valid stays 1 and out_acc/out_ovf update.
//  A beat with clear=1 and last=1 gives a single-term result (acc = p).
//  in_valid=0 cycles are bubbles: S1 valid=0, S2 holds.
//  Without in_clear, the first beat after reset or after last starts from 0.
//  Inputs are ignored while in_ready=0. Out_* stay stable while stalled.
// CONFIGURATION
//  MAC_ARRAY_PIPE_SAT_EN defined:
//  - An overflowing product or sum clamps to 2^(N-1)-1 or -2^(N-1) by sign.
//  - The out_ovf bit is set.
//  MAC_ARRAY_PIPE_SAT_EN undefined:
//  - Product and sum wrap modulo 2^N (low N bits kept).
//  - out_ovf still reports the overflow.
//  Timing and handshake are identical in both builds.
// TESTING  (N=32, Q=10, LANES=4; 1.0 = 1024)
//  1. Reset: rst_n=0, then release -> out_valid=0, out_acc=0, out_ovf=0, in_ready=1.
//  2. Lane0 single-term stream: clear=1, last=1, a=2048, b=1536 -> out_acc lane0 = 3072 one edge after acceptance, out_ovf=0.
//  3. Lane0 three-beat stream, each (2048,1536), clear on beat 1, last on beat 3, out_ready=1 ->
//     out_acc lane0 = 9216, then the next stream starts from 0.
//  4. Backpressure: out_ready=0 while a result is pending ->
//     in_ready=0, out_acc held stable, no beat lost; out_ready=1 releases it next cycle.
//  5. Overflow: a=b=0x0100_0000, clear=1, last=1 ->
//     SAT_EN build: out_acc=0x7FFF_FFFF, out_ovf=1.
//     Non-SAT build: out_acc=0 (low 32 bits of 2^38), out_ovf=1.
//  6. Mid-stream: assert rst_n=0 during beat 2 of a stream ->
//     all outputs 0, and the next stream's result excludes the pre-reset terms.

Source files
------------

// File: rtl/mac_array_pipe.sv
// mac_array_pipe: LANES-wide pipelined signed fixed-point dot-product MAC.
// Optional build macro MAC_ARRAY_PIPE_SAT_EN selects saturation over wrap.
module mac_array_pipe #(
  parameter int N     = 32,
  parameter int Q     = 10,
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_clear,
  input  logic               in_last,
  input  logic [LANES*N-1:0] a,
  input  logic [LANES*N-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] out_acc,
  output logic [LANES-1:0]   out_ovf
);

  localparam logic [N-1:0] MAX_V = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

  logic                    stall;
  logic                    s1_valid;
  logic                    s1_clear;
  logic                    s1_last;
  logic [N-1:0]            s1_p [LANES];
  logic [LANES-1:0]        s1_povf;
  logic [N-1:0]            acc [LANES];
  logic [LANES-1:0]        stk;
  logic signed [2*N-1:0]   op_a [LANES];
  logic signed [2*N-1:0]   op_b [LANES];
  logic signed [2*N-1:0]   p_full [LANES];
  logic [2*N-1:0]          p_sh [LANES];
  logic [N-1:0]            p_d [LANES];
  logic [LANES-1:0]        povf_d;
  logic [N-1:0]            base [LANES];
  logic [N:0]              sum [LANES];
  logic [LANES-1:0]        add_ovf;
  logic [N-1:0]            acc_nx [LANES];
  logic [LANES-1:0]        stk_nx;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Multiply stage: scaled product per lane plus out-of-range flag
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      op_a[i]   = {{N{a[i*N+N-1]}}, a[i*N +: N]};
      op_b[i]   = {{N{b[i*N+N-1]}}, b[i*N +: N]};
      p_full[i] = op_a[i] * op_b[i];
      p_sh[i]   = p_full[i] >>> Q;
      povf_d[i] = (|p_sh[i][2*N-1:N-1])
                & ~(&p_sh[i][2*N-1:N-1]);
`ifdef MAC_ARRAY_PIPE_SAT_EN
      if (povf_d[i])
        p_d[i] = p_sh[i][2*N-1] ? MIN_V : MAX_V;
      else
        p_d[i] = p_sh[i][N-1:0];
`else
      p_d[i] = p_sh[i][N-1:0];
`endif
    end
  end

  // Accumulate stage: next sum and sticky overflow per lane
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      base[i]    = s1_clear ? '0 : acc[i];
      sum[i]     = {base[i][N-1], base[i]}
                 + {s1_p[i][N-1], s1_p[i]};
      add_ovf[i] = sum[i][N] ^ sum[i][N-1];
`ifdef MAC_ARRAY_PIPE_SAT_EN
      if (add_ovf[i])
        acc_nx[i] = sum[i][N] ? MIN_V : MAX_V;
      else
        acc_nx[i] = sum[i][N-1:0];
`else
      acc_nx[i] = sum[i][N-1:0];
`endif
      stk_nx[i] = (~s1_clear & stk[i])
                | s1_povf[i] | add_ovf[i];
    end
  end

  // Product pipeline register, frozen while the result is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_clear <= 1'b0;
      s1_last  <= 1'b0;
      s1_povf  <= '0;
      for (int i = 0; i < LANES; i++)
        s1_p[i] <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      s1_clear <= in_clear;
      s1_last  <= in_last;
      s1_povf  <= povf_d;
      for (int i = 0; i < LANES; i++)
        s1_p[i] <= p_d[i];
    end
  end

  // Accumulators and result register; a last beat rearms acc at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk       <= '0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= '0;
      for (int i = 0; i < LANES; i++)
        acc[i] <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid & s1_last;
      if (s1_valid) begin
        if (s1_last) begin
          stk     <= '0;
          out_ovf <= stk_nx;
        end else begin
          stk <= stk_nx;
        end
        for (int i = 0; i < LANES; i++) begin
          if (s1_last) begin
            acc[i]            <= '0;
            out_acc[i*N +: N] <= acc_nx[i];
          end else begin
            acc[i] <= acc_nx[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_array_pipe.sv
// tb_mac_array_pipe: scoreboard bench for mac_array_pipe.
// Reference model follows MAC_ARRAY_PIPE_SAT_EN like the design.
module tb_mac_array_pipe;

  localparam int N = 32;
  localparam int Q = 10;
  localparam int L = 4;
  localparam int W = L * N;
  localparam longint MAXL = 64'sd2147483647;
  localparam longint MINL = -64'sd2147483648;

  typedef struct {
    logic [W-1:0] acc;
    logic [L-1:0] ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_clear;
  logic         in_last;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_acc;
  logic [L-1:0] out_ovf;

  exp_t   q[$];
  longint macc[L];
  bit     mstk[L];
  bit     fresh;
  int     total;
  int     bad;
  logic [W-1:0] seen_acc;
  logic [L-1:0] seen_ovf;

  mac_array_pipe #(.N(N), .Q(Q), .LANES(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_clear(in_clear), .in_last(in_last),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_acc(out_acc), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] vec(input logic [31:0] v0,
                                       input bit full);
    logic [W-1:0] v;
    v[31:0] = v0;
    for (int l = 1; l < L; l++)
      v[l*N +: N] = full ? $urandom
                         : 32'($urandom_range(0, 4095));
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    fresh = 1'b1;
    for (int l = 0; l < L; l++) begin
      macc[l] = 0;
      mstk[l] = 1'b0;
    end
  endtask

  // Drive one beat from a negedge; returns at the next negedge.
  task automatic beat(input logic clr, input logic lst,
                      input logic [W-1:0] av,
                      input logic [W-1:0] bv);
    exp_t e;
    int   c;
    bit   ok;
    in_valid = 1'b1;
    in_clear = clr;
    in_last  = lst;
    a        = av;
    b        = bv;
    c = 0;
    while (!in_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    ok = in_ready;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL beat_accept in_ready=%0b want 1", in_ready);
    end
    @(posedge clk);
    if (ok) begin
      for (int l = 0; l < L; l++) begin
        longint pa, pb, p, bs, s;
        bit po, ao, st;
        pa = longint'($signed(av[l*N +: N]));
        pb = longint'($signed(bv[l*N +: N]));
        p  = (pa * pb) >>> Q;
        po = (p > MAXL) || (p < MINL);
`ifdef MAC_ARRAY_PIPE_SAT_EN
        if (po) p = (p < 0) ? MINL : MAXL;
`else
        if (po) p = longint'($signed(p[31:0]));
`endif
        bs = (clr || fresh) ? 0 : macc[l];
        s  = bs + p;
        ao = (s > MAXL) || (s < MINL);
`ifdef MAC_ARRAY_PIPE_SAT_EN
        if (ao) s = (s < 0) ? MINL : MAXL;
`else
        if (ao) s = longint'($signed(s[31:0]));
`endif
        st = ((clr || fresh) ? 1'b0 : mstk[l]) | po | ao;
        if (lst) begin
          e.acc[l*N +: N] = s[31:0];
          e.ovf[l]        = st;
        end else begin
          macc[l] = s;
          mstk[l] = st;
        end
      end
      if (lst) q.push_back(e);
      fresh = lst;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_clear  = 1'b0;
    in_last   = 1'b0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total += 4;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid got=%0b want 0", out_valid);
    end
    if (out_acc !== '0) begin
      bad++;
      $display("FAIL reset_acc got=%h want 0", out_acc);
    end
    if (out_ovf !== '0) begin
      bad++;
      $display("FAIL reset_ovf got=%h want 0", out_ovf);
    end
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%0b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    exp_t e;
    beat(1'b1, 1'b1, vec(32'd2048, 0), vec(32'd1536, 0));
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_early got=%0b want 0", out_valid);
    end
    @(negedge clk);
    total += 4;
    if (out_valid !== 1'b1 || q.size() == 0) begin
      bad++;
      $display("FAIL single_valid got=%0b want 1", out_valid);
    end else begin
      e = q.pop_front();
      if (out_acc !== e.acc) begin
        bad++;
        $display("FAIL single_acc got=%h want %h", out_acc, e.acc);
      end
      if (out_ovf !== e.ovf) begin
        bad++;
        $display("FAIL single_ovf got=%h want %h", out_ovf, e.ovf);
      end
    end
    if (out_acc[31:0] !== 32'd3072) begin
      bad++;
      $display("FAIL single_lane0 got=%0d want 3072", out_acc[31:0]);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drop got=%0b want 0", out_valid);
    end
  endtask

  task automatic test_stream();
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        beat(1'b1, 1'b0, vec(32'd2048, 0), vec(32'd1536, 0));
        beat(1'b0, 1'b0, vec(32'd2048, 0), vec(32'd1536, 0));
        beat(1'b0, 1'b1, vec(32'd2048, 0), vec(32'd1536, 0));
      end else begin
        beat(1'b0, 1'b1, vec(32'd1024, 0), vec(32'd1024, 0));
      end
      for (int c = 0; c < 10 && q.size() > 0; c++) begin
        if (out_valid && out_ready) begin
          e = q.pop_front();
          seen_acc = out_acc;
          total += 2;
          if (out_acc !== e.acc) begin
            bad++;
            $display("FAIL stream_acc got=%h want %h", out_acc, e.acc);
          end
          if (out_ovf !== e.ovf) begin
            bad++;
            $display("FAIL stream_ovf got=%h want %h", out_ovf, e.ovf);
          end
        end
        @(negedge clk);
      end
      total += 2;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL stream_timeout left=%0d want 0", q.size());
      end
      if (seen_acc[31:0] !== ((s == 0) ? 32'd9216 : 32'd1024)) begin
        bad++;
        $display("FAIL stream_lane0 s=%0d got=%0d", s, seen_acc[31:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t ea, eb;
    out_ready = 1'b0;
    beat(1'b1, 1'b1, vec(32'd3000, 0), vec(32'd2000, 0));
    beat(1'b1, 1'b1, vec(32'd5000, 0), vec(32'd700, 0));
    ea = q.pop_front();
    eb = q.pop_front();
    for (int c = 0; c < 4; c++) begin
      total += 3;
      if (in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_ready c=%0d got=%0b want 0", c, in_ready);
      end
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_valid c=%0d got=%0b want 1", c, out_valid);
      end
      if (out_acc !== ea.acc) begin
        bad++;
        $display("FAIL bp_hold c=%0d got=%h want %h", c, out_acc, ea.acc);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    total += 3;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_second_valid got=%0b want 1", out_valid);
    end
    if (out_acc !== eb.acc) begin
      bad++;
      $display("FAIL bp_second_acc got=%h want %h", out_acc, eb.acc);
    end
    if (out_ovf !== eb.ovf) begin
      bad++;
      $display("FAIL bp_second_ovf got=%h want %h", out_ovf, eb.ovf);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got=%0b want 0", out_valid);
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    logic [31:0] want;
`ifdef MAC_ARRAY_PIPE_SAT_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'h0;
`endif
    beat(1'b1, 1'b1, vec(32'h0100_0000, 1), vec(32'h0100_0000, 1));
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        e = q.pop_front();
        seen_acc = out_acc;
        seen_ovf = out_ovf;
        total += 2;
        if (out_acc !== e.acc) begin
          bad++;
          $display("FAIL ovf_acc got=%h want %h", out_acc, e.acc);
        end
        if (out_ovf !== e.ovf) begin
          bad++;
          $display("FAIL ovf_flags got=%h want %h", out_ovf, e.ovf);
        end
      end
      @(negedge clk);
    end
    total += 3;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL ovf_timeout left=%0d want 0", q.size());
    end
    if (seen_acc[31:0] !== want) begin
      bad++;
      $display("FAIL ovf_lane0 got=%h want %h", seen_acc[31:0], want);
    end
    if (seen_ovf[0] !== 1'b1) begin
      bad++;
      $display("FAIL ovf_bit got=%0b want 1", seen_ovf[0]);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int r = 0; r < 3; r++) begin
      int nb;
      bit clr0;
      nb   = (r == 0) ? 2 : $urandom_range(1, 4);
      clr0 = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (r == 0) begin
        beat(1'b1, 1'b1, vec($urandom, 1), vec($urandom, 1));
        beat(1'b1, 1'b1, vec($urandom, 1), vec($urandom, 1));
      end else begin
        for (int k = 0; k < nb; k++)
          beat((k == 0) ? clr0 : 1'b0, (k == nb - 1),
               vec($urandom, 1), vec($urandom, 1));
      end
      for (int c = 0; c < 10 && q.size() > 0; c++) begin
        if (out_valid && out_ready) begin
          e = q.pop_front();
          total += 2;
          if (out_acc !== e.acc) begin
            bad++;
            $display("FAIL b2b_acc r=%0d got=%h want %h", r, out_acc, e.acc);
          end
          if (out_ovf !== e.ovf) begin
            bad++;
            $display("FAIL b2b_ovf r=%0d got=%h want %h", r, out_ovf, e.ovf);
          end
        end
        @(negedge clk);
      end
      total++;
      if (q.size() != 0) begin
        bad++;
        $display("FAIL b2b_timeout r=%0d left=%0d", r, q.size());
      end
    end
  endtask

  task automatic test_midreset();
    exp_t e;
    out_ready = 1'b0;
    beat(1'b1, 1'b1, vec(32'd4096, 0), vec(32'd4096, 0));
    beat(1'b1, 1'b0, vec(32'd9999, 0), vec(32'd7777, 0));
    in_valid = 1'b1;
    in_clear = 1'b0;
    in_last  = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total += 3;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_valid got=%0b want 0", out_valid);
    end
    if (out_acc !== '0) begin
      bad++;
      $display("FAIL mid_acc got=%h want 0", out_acc);
    end
    if (out_ovf !== '0) begin
      bad++;
      $display("FAIL mid_ovf got=%h want 0", out_ovf);
    end
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    beat(1'b0, 1'b0, vec(32'd1024, 0), vec(32'd3072, 0));
    beat(1'b0, 1'b1, vec(32'd1024, 0), vec(32'd1024, 0));
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        e = q.pop_front();
        seen_acc = out_acc;
        total++;
        if (out_acc !== e.acc) begin
          bad++;
          $display("FAIL mid_next got=%h want %h", out_acc, e.acc);
        end
      end
      @(negedge clk);
    end
    total += 2;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL mid_timeout left=%0d want 0", q.size());
    end
    if (seen_acc[31:0] !== 32'd4096) begin
      bad++;
      $display("FAIL mid_lane0 got=%0d want 4096", seen_acc[31:0]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    seen_acc = '0;
    seen_ovf = '0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_overflow();
    test_back_to_back();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
